// File: rtl/tcm_arb_ctrl.sv
// Two-port (IFU read-only, LSU read/write) controller for one single-port synchronous TCM SRAM.
// Per-cycle round-robin arbitration, one outstanding request per port, stall-safe read data.

module tcm_rsp_slot #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept,
  input  logic          acc_err,
  input  logic          acc_rd,
  input  logic          rsp_ready,
  input  logic [DW-1:0] ram_dout,
  output logic          free,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata
);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_PEND,
    SLOT_HOLD
  } slot_e;

  slot_e         state_q, state_d;
  logic          err_q, err_d;
  logic          rd_q, rd_d;
  logic [DW-1:0] hold_q, hold_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rd_d    = rd_q;
    hold_d  = hold_q;
    if (accept) begin
      state_d = SLOT_PEND;
      err_d   = acc_err;
      rd_d    = acc_rd;
    end else if ((state_q != SLOT_IDLE) && rsp_ready) begin
      state_d = SLOT_IDLE;
      err_d   = 1'b0;
      rd_d    = 1'b0;
    end else if (state_q == SLOT_PEND) begin
      // SRAM output is only valid for one cycle; freeze it before it moves on.
      state_d = SLOT_HOLD;
      hold_d  = rd_q ? ram_dout : '0;
    end
  end

  // NOTE: state uses non-blocking assignments; the data holding register is reset too,
  // so rdata reads zero out of reset rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_IDLE;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    rsp_valid = (state_q != SLOT_IDLE);
    rsp_err   = err_q;
    free      = (state_q == SLOT_IDLE) || rsp_ready;
    unique case (state_q)
      SLOT_PEND: rsp_rdata = rd_q ? ram_dout : '0;
      SLOT_HOLD: rsp_rdata = hold_q;
      default:   rsp_rdata = '0;
    endcase
  end

endmodule

module tcm_arb_ctrl #(
  parameter  int AW  = 16,
  parameter  int DW  = 32,
  localparam int MW  = DW / 8,
  localparam int RAW = AW - $clog2(MW)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ifu_cmd_valid,
  output logic           ifu_cmd_ready,
  input  logic [AW-1:0]  ifu_cmd_addr,
  output logic           ifu_rsp_valid,
  input  logic           ifu_rsp_ready,
  output logic [DW-1:0]  ifu_rsp_rdata,
  output logic           ifu_rsp_err,
  input  logic           lsu_cmd_valid,
  output logic           lsu_cmd_ready,
  input  logic           lsu_cmd_read,
  input  logic [AW-1:0]  lsu_cmd_addr,
  input  logic [MW-1:0]  lsu_cmd_wmask,
  input  logic [DW-1:0]  lsu_cmd_wdata,
  output logic           lsu_rsp_valid,
  input  logic           lsu_rsp_ready,
  output logic [DW-1:0]  lsu_rsp_rdata,
  output logic           lsu_rsp_err,
  output logic           ram_cs,
  output logic           ram_we,
  output logic [RAW-1:0] ram_addr,
  output logic [MW-1:0]  ram_wem,
  output logic [DW-1:0]  ram_din,
  input  logic [DW-1:0]  ram_dout
);

  localparam int OFF = $clog2(MW);

  typedef enum logic {
    PTR_IFU,
    PTR_LSU
  } ptr_e;

  ptr_e ptr_q, ptr_d;
  logic ifu_free, lsu_free;
  logic ifu_elig, lsu_elig;
  logic ifu_mis, lsu_mis;
  logic ifu_need, lsu_need;
  logic ifu_gnt, lsu_gnt;
  logic ifu_accept, lsu_accept;

  // IFU fetches at instruction granularity and reads the containing DW word.
  assign ifu_mis  = (ifu_cmd_addr[1:0] != 2'b00);
  assign lsu_mis  = (lsu_cmd_addr[OFF-1:0] != '0);
  assign ifu_elig = ifu_cmd_valid && ifu_free;
  assign lsu_elig = lsu_cmd_valid && lsu_free;
  assign ifu_need = ifu_elig && !ifu_mis;
  assign lsu_need = lsu_elig && !lsu_mis;

  always_comb begin
    ifu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    ptr_d   = ptr_q;
    if (ifu_need && lsu_need) begin
      ifu_gnt = (ptr_q == PTR_IFU);
      lsu_gnt = (ptr_q == PTR_LSU);
      ptr_d   = (ptr_q == PTR_IFU) ? PTR_LSU : PTR_IFU;
    end else begin
      ifu_gnt = ifu_need;
      lsu_gnt = lsu_need;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_IFU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Misaligned requests bypass the SRAM, so they never compete for it.
  assign ifu_cmd_ready = ifu_elig && (ifu_mis || ifu_gnt);
  assign lsu_cmd_ready = lsu_elig && (lsu_mis || lsu_gnt);
  assign ifu_accept    = ifu_cmd_valid && ifu_cmd_ready;
  assign lsu_accept    = lsu_cmd_valid && lsu_cmd_ready;

  always_comb begin
    ram_cs   = ifu_gnt || lsu_gnt;
    ram_we   = lsu_gnt && !lsu_cmd_read;
    ram_addr = lsu_gnt ? lsu_cmd_addr[AW-1:OFF] : ifu_cmd_addr[AW-1:OFF];
    ram_wem  = ram_we ? lsu_cmd_wmask : '0;
    ram_din  = lsu_cmd_wdata;
  end

  tcm_rsp_slot #(.DW(DW)) u_ifu_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (ifu_accept),
    .acc_err   (ifu_mis),
    .acc_rd    (!ifu_mis),
    .rsp_ready (ifu_rsp_ready),
    .ram_dout  (ram_dout),
    .free      (ifu_free),
    .rsp_valid (ifu_rsp_valid),
    .rsp_err   (ifu_rsp_err),
    .rsp_rdata (ifu_rsp_rdata)
  );

  tcm_rsp_slot #(.DW(DW)) u_lsu_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (lsu_accept),
    .acc_err   (lsu_mis),
    .acc_rd    (!lsu_mis && lsu_cmd_read),
    .rsp_ready (lsu_rsp_ready),
    .ram_dout  (ram_dout),
    .free      (lsu_free),
    .rsp_valid (lsu_rsp_valid),
    .rsp_err   (lsu_rsp_err),
    .rsp_rdata (lsu_rsp_rdata)
  );

endmodule

// File: tb/tb_tcm_arb_ctrl.sv
// Directed bench for tcm_arb_ctrl with a behavioural 16-word synchronous SRAM.

module tb_tcm_arb_ctrl;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int MW  = 4;
  localparam int RAW = 14;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ifu_cmd_valid, ifu_cmd_ready;
  logic [AW-1:0]  ifu_cmd_addr;
  logic           ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [DW-1:0]  ifu_rsp_rdata;
  logic           lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
  logic [AW-1:0]  lsu_cmd_addr;
  logic [MW-1:0]  lsu_cmd_wmask;
  logic [DW-1:0]  lsu_cmd_wdata;
  logic           lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [DW-1:0]  lsu_rsp_rdata;
  logic           ram_cs, ram_we;
  logic [RAW-1:0] ram_addr;
  logic [MW-1:0]  ram_wem;
  logic [DW-1:0]  ram_din;
  logic [DW-1:0]  ram_dout;

  logic           load;
  logic [DW-1:0]  mem [0:15];
  int             n_checks = 0;
  int             n_fail   = 0;

  always #5 clk = ~clk;

  tcm_arb_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_cmd_valid (ifu_cmd_valid),
    .ifu_cmd_ready (ifu_cmd_ready),
    .ifu_cmd_addr  (ifu_cmd_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_cmd_valid (lsu_cmd_valid),
    .lsu_cmd_ready (lsu_cmd_ready),
    .lsu_cmd_read  (lsu_cmd_read),
    .lsu_cmd_addr  (lsu_cmd_addr),
    .lsu_cmd_wmask (lsu_cmd_wmask),
    .lsu_cmd_wdata (lsu_cmd_wdata),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .lsu_rsp_err   (lsu_rsp_err),
    .ram_cs        (ram_cs),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wem       (ram_wem),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout)
  );

  // Single-port SRAM: read data appears the cycle after chip select.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[1]   <= 32'hDEADBEEF;
      mem[2]   <= 32'hAAAAAAAA;
      mem[4]   <= 32'h44444444;
      mem[5]   <= 32'h55555555;
      ram_dout <= '0;
    end else if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++) begin
          if (ram_wem[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_din[8*b +: 8];
        end
      end else begin
        ram_dout <= mem[ram_addr[3:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load = 1'b1;
    ifu_cmd_valid = 0; ifu_cmd_addr = '0; ifu_rsp_ready = 0;
    lsu_cmd_valid = 0; lsu_cmd_read = 0; lsu_cmd_addr = '0;
    lsu_cmd_wmask = '0; lsu_cmd_wdata = '0; lsu_rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    load = 1'b0;
    check("rst_ifu_valid", ifu_rsp_valid, 0);
    check("rst_lsu_valid", lsu_rsp_valid, 0);
    check("rst_ifu_rdata", ifu_rsp_rdata, 0);
    check("rst_lsu_rdata", lsu_rsp_rdata, 0);
    check("rst_lsu_err", lsu_rsp_err, 0);
    check("rst_ram_cs", ram_cs, 0);
    rst_n = 1'b1;

    // Single IFU read of word 1
    ifu_cmd_valid = 1; ifu_cmd_addr = 16'h0004; ifu_rsp_ready = 1;
    #1;
    check("t1_ifu_ready", ifu_cmd_ready, 1);
    check("t1_ram_cs", ram_cs, 1);
    check("t1_ram_addr", ram_addr, 1);
    check("t1_ram_we", ram_we, 0);
    step();
    ifu_cmd_valid = 0;
    check("t1_rsp_valid", ifu_rsp_valid, 1);
    check("t1_rsp_rdata", ifu_rsp_rdata, 32'hDEADBEEF);
    check("t1_rsp_err", ifu_rsp_err, 0);
    step();
    check("t1_rsp_done", ifu_rsp_valid, 0);

    // Both ports contend for four cycles: IFU, LSU, IFU, LSU
    ifu_cmd_valid = 1; ifu_cmd_addr = 16'h0010;
    lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 16'h0014; lsu_rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      logic exp_ifu;
      exp_ifu = (k % 2 == 0);
      #1;
      check($sformatf("t2_ifu_ready%0d", k), ifu_cmd_ready, exp_ifu);
      check($sformatf("t2_lsu_ready%0d", k), lsu_cmd_ready, !exp_ifu);
      check($sformatf("t2_ram_cs%0d", k), ram_cs, 1);
      check($sformatf("t2_ram_addr%0d", k), ram_addr, exp_ifu ? 4 : 5);
      step();
      check($sformatf("t2_ifu_valid%0d", k), ifu_rsp_valid, exp_ifu);
      check($sformatf("t2_lsu_valid%0d", k), lsu_rsp_valid, !exp_ifu);
      if (exp_ifu) check($sformatf("t2_ifu_rdata%0d", k), ifu_rsp_rdata, 32'h44444444);
      else         check($sformatf("t2_lsu_rdata%0d", k), lsu_rsp_rdata, 32'h55555555);
    end
    ifu_cmd_valid = 0; lsu_cmd_valid = 0;
    step();

    // Masked write then read-back, back to back
    lsu_cmd_valid = 1; lsu_cmd_read = 0; lsu_cmd_addr = 16'h0008;
    lsu_cmd_wmask = 4'b0011; lsu_cmd_wdata = 32'h12345678;
    #1;
    check("t3_wr_ready", lsu_cmd_ready, 1);
    check("t3_ram_we", ram_we, 1);
    check("t3_ram_wem", ram_wem, 4'b0011);
    check("t3_ram_addr", ram_addr, 2);
    step();
    check("t3_wr_rsp_valid", lsu_rsp_valid, 1);
    check("t3_wr_rsp_rdata", lsu_rsp_rdata, 0);
    check("t3_wr_rsp_err", lsu_rsp_err, 0);
    lsu_cmd_read = 1;
    #1;
    check("t3_rd_ready", lsu_cmd_ready, 1);
    check("t3_rd_we", ram_we, 0);
    check("t3_rd_wem", ram_wem, 0);
    step();
    lsu_cmd_valid = 0;
    check("t3_rd_valid", lsu_rsp_valid, 1);
    check("t3_rd_rdata", lsu_rsp_rdata, 32'hAAAA5678);
    step();

    // LSU read stalled for 3 cycles while IFU keeps the SRAM output moving
    lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 16'h0010; lsu_rsp_ready = 0;
    step();
    check("t4_first_rdata", lsu_rsp_rdata, 32'h44444444);
    lsu_cmd_addr = 16'h0014;
    ifu_cmd_valid = 1; ifu_rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      ifu_cmd_addr = (i % 2 == 0) ? 16'h0014 : 16'h0008;
      #1;
      check($sformatf("t4_lsu_ready%0d", i), lsu_cmd_ready, 0);
      step();
      check($sformatf("t4_hold_valid%0d", i), lsu_rsp_valid, 1);
      check($sformatf("t4_hold_rdata%0d", i), lsu_rsp_rdata, 32'h44444444);
    end
    ifu_cmd_valid = 0; lsu_rsp_ready = 1;
    #1;
    check("t4_release_ready", lsu_cmd_ready, 1);
    check("t4_release_rdata", lsu_rsp_rdata, 32'h44444444);
    step();
    lsu_cmd_valid = 0;
    check("t4_next_valid", lsu_rsp_valid, 1);
    check("t4_next_rdata", lsu_rsp_rdata, 32'h55555555);
    step();
    check("t4_idle", lsu_rsp_valid, 0);

    // Misaligned LSU read, alone then alongside an aligned IFU read
    lsu_cmd_valid = 1; lsu_cmd_read = 1; lsu_cmd_addr = 16'h0006;
    #1;
    check("t5_mis_ready", lsu_cmd_ready, 1);
    check("t5_mis_ram_cs", ram_cs, 0);
    step();
    check("t5_mis_valid", lsu_rsp_valid, 1);
    check("t5_mis_err", lsu_rsp_err, 1);
    check("t5_mis_rdata", lsu_rsp_rdata, 0);
    ifu_cmd_valid = 1; ifu_cmd_addr = 16'h0010;
    #1;
    check("t5_both_ifu_ready", ifu_cmd_ready, 1);
    check("t5_both_lsu_ready", lsu_cmd_ready, 1);
    check("t5_both_ram_cs", ram_cs, 1);
    check("t5_both_ram_addr", ram_addr, 4);
    step();
    ifu_cmd_valid = 0; lsu_cmd_valid = 0;
    check("t5_ifu_rdata", ifu_rsp_rdata, 32'h44444444);
    check("t5_ifu_err", ifu_rsp_err, 0);
    check("t5_lsu_err", lsu_rsp_err, 1);
    check("t5_lsu_rdata", lsu_rsp_rdata, 0);
    step();
    check("t5_lsu_err_clear", lsu_rsp_err, 0);

    // Asynchronous reset while an IFU response is outstanding
    ifu_cmd_valid = 1; ifu_cmd_addr = 16'h0004; ifu_rsp_ready = 0;
    step();
    ifu_cmd_valid = 0;
    check("t6_pre_valid", ifu_rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", ifu_rsp_valid, 0);
    check("t6_rst_rdata", ifu_rsp_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifu_rsp_ready = 1; ifu_cmd_valid = 1; ifu_cmd_addr = 16'h0008;
    #1;
    check("t6_post_ready", ifu_cmd_ready, 1);
    check("t6_post_addr", ram_addr, 2);
    step();
    ifu_cmd_valid = 0;
    check("t6_post_valid", ifu_rsp_valid, 1);
    check("t6_post_rdata", ifu_rsp_rdata, 32'hAAAA5678);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
